regfile_mp: RTL and testbench

- Parametrised successor to the single-write, two-read integer register file.
- Configurable data width, register count and number of read ports.
- Adds write-to-read bypass, an optional registered-read mode, and a hardware clear sweep after reset or on request.
- Sits in the ID stage; write port is driven from WB.

---
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register file access bundle: read ports, single write port, clear request and sweep status.
// Latency: n/a (wiring only); widths follow the XLEN/NREGS/NREAD of the attached regfile_mp.
// Backpressure: none; busy tells the master that writes are dropped and reads return zero.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic                  clear_req;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  busy;

    modport master (
        output clear_req, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, busy
    );

    modport slave (
        input  clear_req, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with r0 hardwired to zero, optional bypass and a clear sweep.
// Latency: reads combinational (RD_REG=0) or one cycle (RD_REG=1); clear sweep takes NREGS cycles.
// Backpressure: none; while busy, writes are dropped and every read port returns zero.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int RD_REG = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave rf
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [AW-1:0]         sweep_cnt;
    logic                  busy_q;
    logic [XLEN-1:0]       regs [NREGS];
    logic                  wr_ok;
    logic [NREAD*XLEN-1:0] rd_comb;

    // Reset lands directly in CLEAR so the array (which has no reset) is zeroed before first use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            busy_q    <= 1'b1;
        end else if (state == IDLE) begin
            if (rf.clear_req) begin
                state     <= CLEAR;
                sweep_cnt <= '0;
                busy_q    <= 1'b1;
            end
        end else begin
            sweep_cnt <= sweep_cnt + AW'(1);
            if (sweep_cnt == AW'(NREGS - 1)) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end
        end
    end

    assign wr_ok = (state == IDLE) && rf.wr_en && (rf.wr_addr != '0);

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[sweep_cnt] <= '0;
        end else if (wr_ok) begin
            regs[rf.wr_addr] <= rf.wr_data;
        end
    end

    // Address 0 and the whole sweep read as zero, bypass included.
    always_comb begin
        rd_comb = '0;
        for (int k = 0; k < NREAD; k++) begin
            if ((state == IDLE) && (rf.rd_addr[k*AW +: AW] != '0)) begin
                if ((BYPASS != 0) && wr_ok && (rf.wr_addr == rf.rd_addr[k*AW +: AW])) begin
                    rd_comb[k*XLEN +: XLEN] = rf.wr_data;
                end else begin
                    rd_comb[k*XLEN +: XLEN] = regs[rf.rd_addr[k*AW +: AW]];
                end
            end
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [NREAD*XLEN-1:0] rd_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_comb;
                end
            end

            assign rf.rd_data = rd_q;
        end else begin : g_rd_comb
            assign rf.rd_data = rd_comb;
        end
    endgenerate

    assign rf.busy = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances (bypass comb, no-bypass comb, 4-port registered).
// Expected values are queued when stimulus is driven and popped when the output is sampled.
module tb_regfile_mp;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) if_a ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) if_b ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(4)) if_c ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .RD_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rf(if_a));
    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0), .RD_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rf(if_b));
    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(4), .BYPASS(1), .RD_REG(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .rf(if_c));

    int checks = 0;
    int errors = 0;
    string        sb_tag [$];
    logic [127:0] sb_exp [$];

    task automatic expect_val(input string tag, input logic [127:0] v);
        sb_tag.push_back(tag);
        sb_exp.push_back(v);
    endtask

    task automatic check(input logic [127:0] obs);
        string        tag;
        logic [127:0] exp;
        checks++;
        assert (sb_exp.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=queued_entry", obs);
        end
        if (sb_exp.size() != 0) begin
            tag = sb_tag.pop_front();
            exp = sb_exp.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_all(input logic en, input logic [4:0] addr, input logic [31:0] d);
        if_a.wr_en = en; if_a.wr_addr = addr; if_a.wr_data = d;
        if_b.wr_en = en; if_b.wr_addr = addr; if_b.wr_data = d;
        if_c.wr_en = en; if_c.wr_addr = addr; if_c.wr_data = d;
    endtask

    task automatic clr_all(input logic v);
        if_a.clear_req = v;
        if_b.clear_req = v;
        if_c.clear_req = v;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] d);
        wr_all(1'b1, addr, d);
        next();
        wr_all(1'b0, 5'd0, 32'd0);
    endtask

    // Counts consecutive busy samples on instance a, bounded so a stuck sweep still terminates.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_a.busy) n++;
            else break;
        end
        next();
    endtask

    int nb;

    initial begin
        clr_all(1'b0);
        wr_all(1'b0, 5'd0, 32'd0);
        if_a.rd_addr = '0;
        if_b.rd_addr = '0;
        if_c.rd_addr = '0;

        // Reset and initial sweep
        @(negedge clk);
        expect_val("reset_busy", 128'd1);
        check(128'(if_a.busy));
        expect_val("reset_rd_reg_zero", 128'd0);
        check(128'(if_c.rd_data));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_val("reset_sweep_len", 128'd32);
        count_busy(nb);
        check(128'(nb));
        if_a.rd_addr = {5'd31, 5'd5};
        expect_val("post_sweep_busy", 128'd0);
        expect_val("post_sweep_read", 128'd0);
        @(negedge clk);
        check(128'(if_a.busy));
        check(128'(if_a.rd_data));
        next();

        // Write then read, r0 stays zero
        write_reg(5'd7, 32'hDEADBEEF);
        if_a.rd_addr = {5'd0, 5'd7};
        expect_val("read_r7", {96'd0, 32'hDEADBEEF});
        @(negedge clk);
        check(128'(if_a.rd_data));
        next();
        wr_all(1'b1, 5'd0, 32'h1234);
        if_a.rd_addr = {5'd0, 5'd0};
        expect_val("r0_bypass_zero", 128'd0);
        @(negedge clk);
        check(128'(if_a.rd_data));
        next();
        wr_all(1'b0, 5'd0, 32'd0);
        expect_val("r0_read_zero", 128'd0);
        @(negedge clk);
        check(128'(if_a.rd_data));
        next();

        // Bypass vs. no bypass
        write_reg(5'd3, 32'h5);
        wr_all(1'b1, 5'd3, 32'hA5A5A5A5);
        if_a.rd_addr = {5'd3, 5'd0};
        if_b.rd_addr = {5'd3, 5'd0};
        expect_val("bypass_same_cycle", {64'd0, 32'hA5A5A5A5, 32'd0});
        expect_val("nobypass_old_value", {64'd0, 32'h5, 32'd0});
        @(negedge clk);
        check(128'(if_a.rd_data));
        check(128'(if_b.rd_data));
        next();
        wr_all(1'b0, 5'd0, 32'd0);
        expect_val("nobypass_next_cycle", {64'd0, 32'hA5A5A5A5, 32'd0});
        @(negedge clk);
        check(128'(if_b.rd_data));
        next();

        // Registered 4-port read
        write_reg(5'd2, 32'h11);
        write_reg(5'd4, 32'h22);
        if_c.rd_addr = {5'd2, 5'd4, 5'd4, 5'd0};
        expect_val("rdreg_not_yet", 128'd0);
        @(negedge clk);
        check(128'(if_c.rd_data));
        next();
        expect_val("rdreg_one_cycle", {32'h11, 32'h22, 32'h22, 32'h0});
        @(negedge clk);
        check(128'(if_c.rd_data));
        next();
        if_c.rd_addr = {5'd0, 5'd0, 5'd0, 5'd5};
        wr_all(1'b1, 5'd5, 32'h77);
        expect_val("rdreg_bypass_hold", {32'h11, 32'h22, 32'h22, 32'h0});
        @(negedge clk);
        check(128'(if_c.rd_data));
        next();
        wr_all(1'b0, 5'd0, 32'd0);
        expect_val("rdreg_bypass_late", {96'd0, 32'h77});
        @(negedge clk);
        check(128'(if_c.rd_data));
        next();

        // Soft clear with dropped write and ignored second request
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
        if_a.rd_addr = {5'd31, 5'd9};
        expect_val("fill_read", {64'd0, 32'd31, 32'd9});
        @(negedge clk);
        check(128'(if_a.rd_data));
        next();
        clr_all(1'b1);
        next();
        clr_all(1'b0);
        nb = 0;
        for (int n = 0; n < 40; n++) begin
            clr_all(n == 10);
            if (n == 20) wr_all(1'b1, 5'd9, 32'h99);
            else wr_all(1'b0, 5'd0, 32'd0);
            @(negedge clk);
            if (if_a.busy) nb++;
            if (n == 20) begin
                expect_val("read_during_clear", 128'd0);
                check(128'(if_a.rd_data));
            end
            next();
        end
        expect_val("soft_clear_len", 128'd32);
        check(128'(nb));
        for (int i = 0; i < 32; i++) begin
            if_a.rd_addr = {5'(31 - i), 5'(i)};
            expect_val("cleared_read", 128'd0);
            @(negedge clk);
            check(128'(if_a.rd_data));
            next();
        end

        // Reset in the middle of a sweep
        write_reg(5'd12, 32'hC);
        clr_all(1'b1);
        next();
        clr_all(1'b0);
        repeat (15) next();
        rst_n = 1'b0;
        expect_val("midsweep_reset_busy", 128'd1);
        @(negedge clk);
        check(128'(if_a.busy));
        next();
        next();
        rst_n = 1'b1;
        expect_val("midsweep_restart_len", 128'd32);
        count_busy(nb);
        check(128'(nb));
        if_a.rd_addr = {5'd0, 5'd12};
        expect_val("after_restart_r12", 128'd0);
        @(negedge clk);
        check(128'(if_a.rd_data));
        next();

        expect_val("scoreboard_drained", 128'd0);
        check(128'(sb_exp.size() - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
